// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: funct3 access codes, FSM states, sizes.
package lsu_pkg;

  localparam int unsigned DATA_W          = 32;
  localparam int unsigned CNT_W           = 16;
  localparam int unsigned TIMEOUT_DEFAULT = 255;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {IDLE, ACCESS} lsu_state_t;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} lsu_size_t;

  // Unknown encodings fall back to a full-word access.
  function automatic lsu_size_t size_of(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: size_of = SZ_B;
      F3_H, F3_HU: size_of = SZ_H;
      default:     size_of = SZ_W;
    endcase
  endfunction

  // Byte lane actually addressed once the low bits irrelevant to the size are dropped.
  function automatic logic [1:0] lane_of(input lsu_size_t sz, input logic [1:0] a);
    case (sz)
      SZ_B:    lane_of = a;
      SZ_H:    lane_of = {a[1], 1'b0};
      default: lane_of = 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store replication, load extract/extend.
// The misal output exists only when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]        st_funct3,
  input  logic [1:0]        st_a,
  input  logic [DATA_W-1:0] st_data,
  output logic [3:0]        st_be,
  output logic [DATA_W-1:0] st_wdata,
  input  logic [2:0]        ld_funct3,
  input  logic [1:0]        ld_a,
  input  logic [DATA_W-1:0] ld_rdata,
  output logic [DATA_W-1:0] ld_data
`ifdef LSU_MISALIGN_TRAP_EN
  ,
  output logic              misal
`endif
);

  lsu_size_t        st_sz;
  lsu_size_t        ld_sz;
  logic [DATA_W-1:0] ld_shift;

  assign st_sz = size_of(st_funct3);
  assign ld_sz = size_of(ld_funct3);

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_sz)
      SZ_B: begin
        st_be    = 4'b0001 << st_a;
        st_wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        st_be    = 4'b0011 << lane_of(SZ_H, st_a);
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign ld_shift = ld_rdata >> {lane_of(ld_sz, ld_a), 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (ld_funct3)
      F3_B:    ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
      F3_BU:   ld_data = {24'h0, ld_shift[7:0]};
      F3_H:    ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
      F3_HU:   ld_data = {16'h0, ld_shift[15:0]};
      default: ;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal = ((st_sz == SZ_H) && st_a[0]) || ((st_sz == SZ_W) && (st_a != 2'b00));
`endif

endmodule

// File: rtl/load_store_unit.sv
// Memory stage: drives the data-memory handshake for loads/stores and forwards ALU results.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [DATA_W-1:0] ALUResult,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  input  logic [2:0]        funct3,
  input  logic [4:0]        RdIn,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              bus_err,
  output logic              misaligned
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t        state;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        f3_q;
  logic [1:0]        a_q;
  logic [4:0]        rd_q;
  logic              rw_q;
  logic [3:0]        be_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] ldata_c;
  logic              trap_c;

  lsu_align u_align (
    .st_funct3 (funct3),
    .st_a      (ALUResult[1:0]),
    .st_data   (WriteData),
    .st_be     (be_c),
    .st_wdata  (wdata_c),
    .ld_funct3 (f3_q),
    .ld_a      (a_q),
    .ld_rdata  (mem_rdata),
    .ld_data   (ldata_c)
`ifdef LSU_MISALIGN_TRAP_EN
    ,
    .misal     (trap_c)
`endif
  );

`ifndef LSU_MISALIGN_TRAP_EN
  assign trap_c = 1'b0;
`endif

  assign ex_ready = rst ? 1'b0 : (state == IDLE);

  // FSM, timeout counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      f3_q       <= '0;
      a_q        <= '0;
      rd_q       <= '0;
      rw_q       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_be     <= '0;
      mem_wdata  <= '0;
      wb_valid   <= 1'b0;
      wb_data    <= '0;
      wb_rd      <= '0;
      bus_err    <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      wb_valid   <= 1'b0;
      bus_err    <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: begin
          if (ex_valid) begin
            if (MemRead || MemWrite) begin
              if (trap_c) begin
                misaligned <= 1'b1;
              end else begin
                state     <= ACCESS;
                cnt       <= '0;
                mem_req   <= 1'b1;
                mem_we    <= MemWrite;
                mem_addr  <= {ALUResult[31:2], 2'b00};
                mem_be    <= be_c;
                mem_wdata <= wdata_c;
                f3_q      <= funct3;
                a_q       <= ALUResult[1:0];
                rd_q      <= RdIn;
                rw_q      <= RegWrite;
              end
            end else begin
              wb_valid <= RegWrite;
              wb_data  <= ALUResult;
              wb_rd    <= RdIn;
            end
          end
        end
        ACCESS: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (!mem_we) begin
              wb_valid <= rw_q;
              wb_data  <= ldata_c;
              wb_rd    <= rd_q;
            end
          end else if (cnt == CNT_LAST) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            bus_err <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed, table-driven bench for load_store_unit (TIMEOUT_CYCLES=4).
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic        RegWrite;
  logic [2:0]  funct3;
  logic [4:0]  RdIn;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        bus_err;
  logic        misaligned;

  int nchecks = 0;
  int nerrors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ALUResult(ALUResult), .WriteData(WriteData), .MemRead(MemRead),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .funct3(funct3), .RdIn(RdIn),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
    .bus_err(bus_err), .misaligned(misaligned)
  );

  typedef struct {
    string       name;
    logic        mr;
    logic        mw;
    logic        rw;
    logic [2:0]  f3;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          dly;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_wbv;
    logic [31:0] exp_wbd;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic mw, input logic rw, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid  = 1'b1;
    MemRead   = mr;
    MemWrite  = mw;
    RegWrite  = rw;
    funct3    = f3;
    ALUResult = alu;
    WriteData = wd;
    RdIn      = rd;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    drive(v.mr, v.mw, v.rw, v.f3, v.alu, v.wd, v.rd);
    check($sformatf("%s.ready_in", v.name), 32'(ex_ready), 32'd1);
    tick();
    idle_inputs();
    if (!v.mr && !v.mw) begin
      check($sformatf("%s.wb_valid", v.name), 32'(wb_valid), 32'(v.exp_wbv));
      check($sformatf("%s.no_req", v.name), 32'(mem_req), 32'd0);
      if (v.exp_wbv) begin
        check($sformatf("%s.wb_data", v.name), wb_data, v.exp_wbd);
        check($sformatf("%s.wb_rd", v.name), 32'(wb_rd), 32'(v.rd));
      end
    end else begin
      check($sformatf("%s.req", v.name), 32'(mem_req), 32'd1);
      check($sformatf("%s.we", v.name), 32'(mem_we), 32'(v.mw));
      check($sformatf("%s.addr", v.name), mem_addr, v.exp_addr);
      check($sformatf("%s.be", v.name), 32'(mem_be), 32'(v.exp_be));
      if (v.mw) check($sformatf("%s.wdata", v.name), mem_wdata, v.exp_wdata);
      repeat (v.dly - 1) tick();
      check($sformatf("%s.stall", v.name), 32'(ex_ready), 32'd0);
      check($sformatf("%s.be_hold", v.name), 32'(mem_be), 32'(v.exp_be));
      mem_ack   = 1'b1;
      mem_rdata = v.rdata;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
      check($sformatf("%s.req_drop", v.name), 32'(mem_req), 32'd0);
      check($sformatf("%s.ready_out", v.name), 32'(ex_ready), 32'd1);
      check($sformatf("%s.wb_valid", v.name), 32'(wb_valid), 32'(v.exp_wbv));
      if (v.exp_wbv) begin
        check($sformatf("%s.wb_data", v.name), wb_data, v.exp_wbd);
        check($sformatf("%s.wb_rd", v.name), 32'(wb_rd), 32'(v.rd));
      end
    end
  endtask

  initial begin
    //          name     mr    mw    rw    f3      alu           wd            rd     rdata         dly addr          be       wdata         wbv   wbd
    vecs[0]  = '{"pass",  1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_0011, 32'h0,        5'd5,  32'h0,        1, 32'h0,        4'b0000, 32'h0,        1'b1, 32'h0000_0011};
    vecs[1]  = '{"pass0", 1'b0, 1'b0, 1'b0, 3'b000, 32'hDEAD_BEEF, 32'h0,        5'd7,  32'h0,        1, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0};
    vecs[2]  = '{"lb",    1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0,        5'd3,  32'h80FF_FF00, 3, 32'h0000_0100, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80};
    vecs[3]  = '{"lbu",   1'b1, 1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'h0,        5'd4,  32'h80FF_FF00, 3, 32'h0000_0100, 4'b1000, 32'h0,        1'b1, 32'h0000_0080};
    vecs[4]  = '{"sh",    1'b0, 1'b1, 1'b0, 3'b001, 32'h0000_0022, 32'h1234_ABCD, 5'd0,  32'h0,        1, 32'h0000_0020, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0};
    vecs[5]  = '{"lh",    1'b1, 1'b0, 1'b1, 3'b001, 32'h0000_0002, 32'h0,        5'd8,  32'h8001_7FFF, 1, 32'h0000_0000, 4'b1100, 32'h0,        1'b1, 32'hFFFF_8001};
    vecs[6]  = '{"lhu",   1'b1, 1'b0, 1'b1, 3'b101, 32'h0000_0002, 32'h0,        5'd9,  32'h8001_7FFF, 2, 32'h0000_0000, 4'b1100, 32'h0,        1'b1, 32'h0000_8001};
    vecs[7]  = '{"lw",    1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0040, 32'h0,        5'd10, 32'hCAFE_BABE, 1, 32'h0000_0040, 4'b1111, 32'h0,        1'b1, 32'hCAFE_BABE};
    vecs[8]  = '{"sb",    1'b0, 1'b1, 1'b1, 3'b000, 32'h0000_0041, 32'h0000_00A5, 5'd11, 32'h0,        2, 32'h0000_0040, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0};
    vecs[9]  = '{"sw",    1'b0, 1'b1, 1'b0, 3'b010, 32'h0000_0044, 32'h1122_3344, 5'd0,  32'h0,        1, 32'h0000_0044, 4'b1111, 32'h1122_3344, 1'b0, 32'h0};
    vecs[10] = '{"lbpos", 1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0000, 32'h0,        5'd12, 32'hFFFF_FF7F, 1, 32'h0000_0000, 4'b0001, 32'h0,        1'b1, 32'h0000_007F};
    vecs[11] = '{"lundef",1'b1, 1'b0, 1'b1, 3'b011, 32'h0000_0008, 32'h0,        5'd13, 32'h89AB_CDEF, 1, 32'h0000_0008, 4'b1111, 32'h0,        1'b1, 32'h89AB_CDEF};

    rst = 1'b1;
    idle_inputs();
    RegWrite  = 1'b0;
    funct3    = 3'b000;
    ALUResult = '0;
    WriteData = '0;
    RdIn      = '0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    tick();
    tick();
    check("rst.ready", 32'(ex_ready), 32'd0);
    check("rst.req", 32'(mem_req), 32'd0);
    check("rst.addr", mem_addr, 32'd0);
    check("rst.wb_valid", 32'(wb_valid), 32'd0);
    check("rst.wb_data", wb_data, 32'd0);
    check("rst.bus_err", 32'(bus_err), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

    // Back-to-back pass-through accepts.
    drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_00AA, 32'h0, 5'd1);
    tick();
    check("b2b.wb0", wb_data, 32'h0000_00AA);
    check("b2b.ready", 32'(ex_ready), 32'd1);
    drive(1'b0, 1'b0, 1'b1, 3'b000, 32'h0000_00BB, 32'h0, 5'd2);
    tick();
    idle_inputs();
    check("b2b.wbv1", 32'(wb_valid), 32'd1);
    check("b2b.wb1", wb_data, 32'h0000_00BB);
    check("b2b.rd1", 32'(wb_rd), 32'd2);
    tick();
    check("b2b.wbv_end", 32'(wb_valid), 32'd0);

    // Timeout: four request cycles, bus_err pulse, late ack ignored.
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0010, 32'h0, 5'd6);
    tick();
    idle_inputs();
    for (int c = 0; c < 4; c++) begin
      check($sformatf("to.req%0d", c), 32'(mem_req), 32'd1);
      check($sformatf("to.err%0d", c), 32'(bus_err), 32'd0);
      tick();
    end
    check("to.req_drop", 32'(mem_req), 32'd0);
    check("to.bus_err", 32'(bus_err), 32'd1);
    check("to.ready", 32'(ex_ready), 32'd1);
    check("to.no_wb", 32'(wb_valid), 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    tick();
    mem_ack = 1'b0;
    check("to.err_pulse", 32'(bus_err), 32'd0);
    check("late.no_wb", 32'(wb_valid), 32'd0);
    check("late.no_req", 32'(mem_req), 32'd0);
    check("late.ready", 32'(ex_ready), 32'd1);

    // Ack arriving on the last allowed cycle wins over the timeout.
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0014, 32'h0, 5'd14);
    tick();
    idle_inputs();
    repeat (3) tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    tick();
    mem_ack = 1'b0;
    check("edge.no_err", 32'(bus_err), 32'd0);
    check("edge.wbv", 32'(wb_valid), 32'd1);
    check("edge.wbd", wb_data, 32'h0BAD_F00D);

    // Misaligned word load at 0x6.
    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'h0000_0006, 32'h0, 5'd15);
    tick();
    idle_inputs();
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis.pulse", 32'(misaligned), 32'd1);
    check("mis.no_req", 32'(mem_req), 32'd0);
    check("mis.no_wb", 32'(wb_valid), 32'd0);
    check("mis.ready", 32'(ex_ready), 32'd1);
    tick();
    check("mis.pulse_end", 32'(misaligned), 32'd0);
`else
    check("mis.zero", 32'(misaligned), 32'd0);
    check("mis.req", 32'(mem_req), 32'd1);
    check("mis.addr", mem_addr, 32'h0000_0004);
    check("mis.be", 32'(mem_be), 32'h0000_000F);
    mem_ack   = 1'b1;
    mem_rdata = 32'hA1B2_C3D4;
    tick();
    mem_ack = 1'b0;
    check("mis.wbd", wb_data, 32'hA1B2_C3D4);
`endif

    // Reset asserted in the second ACCESS cycle.
    drive(1'b1, 1'b0, 1'b1, 3'b000, 32'h0000_0020, 32'h0, 5'd16);
    tick();
    idle_inputs();
    tick();
    rst = 1'b1;
    #1;
    check("rstacc.ready_low", 32'(ex_ready), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rstacc.req", 32'(mem_req), 32'd0);
    check("rstacc.addr", mem_addr, 32'd0);
    check("rstacc.be", 32'(mem_be), 32'd0);
    check("rstacc.wdata", mem_wdata, 32'd0);
    check("rstacc.wbv", 32'(wb_valid), 32'd0);
    check("rstacc.wbd", wb_data, 32'd0);
    check("rstacc.err", 32'(bus_err), 32'd0);
    check("rstacc.ready", 32'(ex_ready), 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    check("rstacc.ack_wbv", 32'(wb_valid), 32'd0);
    check("rstacc.ack_req", 32'(mem_req), 32'd0);
    check("rstacc.ack_err", 32'(bus_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage placed directly downstream of the execute-stage ALU. It uses the ALU `Result` as the data-memory address for loads and stores, and passes non-memory results through to writeback. For memory operations it runs a request/acknowledge handshake with data memory, generates byte enables and lane-aligned store data, and sign/zero-extends load data. While an access is outstanding it stalls execute.

## Interface
- `TIMEOUT_CYCLES`, 255: ACCESS cycles without `mem_ack` before the access is aborted (1..65535).
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `ex_valid` input 1: execute presents an operation.
- `ex_ready` output 1: unit can accept; `rst ? 0 : (state==IDLE)`.
- `ALUResult` input 32: ALU result; the address for memory ops.
- `WriteData` input 32: store data (rs2).
- `MemRead`, `MemWrite` input 1 each: op class; both 0 means pass-through.
- `RegWrite` input 1: op writes a register.
- `funct3` input 3: access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU).
- `RdIn` input 5: destination register.
- `mem_req` output 1: access request, held until ack or abort.
- `mem_we` output 1: write.
- `mem_addr` output 32: `{ALUResult[31:2],2'b00}`.
- `mem_be` output 4: byte enables.
- `mem_wdata` output 32: lane-aligned store data.
- `mem_ack` input 1: access complete; `mem_rdata` valid in the same cycle.
- `mem_rdata` input 32: read word.
- `wb_valid` output 1: one-cycle writeback pulse.
- `wb_data` output 32, `wb_rd` output 5: writeback value and register.
- `bus_err` output 1: one-cycle pulse on timeout.
- `misaligned` output 1: one-cycle pulse; tied to 0 when the trap is compiled out.

## Operation
- Accept condition: `ex_valid & ex_ready` at a rising edge. All inputs are registered on accept.
- FSM states: IDLE, ACCESS.
  - IDLE: pass-through op returns to IDLE. Memory op goes to ACCESS (or the misaligned path, below).
  - ACCESS: `mem_ack` goes to IDLE. Counter reaching `TIMEOUT_CYCLES` goes to IDLE with `bus_err`.
- Pass-through ops: next cycle `wb_valid=RegWrite`, `wb_data=ALUResult`, `wb_rd=RdIn`.
- Byte enables, with `a = ALUResult[1:0]`:
  - byte: `4'b0001<<a`.
  - half: `4'b0011<<{a[1],1'b0}`.
  - word: `4'b1111`.
  - Undefined `funct3` is treated as word.
- Store data: byte is replicated ×4, half ×2, word unchanged.
- Load data: `mem_rdata >> (8*lane)`, then sign-extend (B/H) or zero-extend (BU/HU).
- Loads: `wb_valid=RegWrite` in the cycle after ack. Stores never assert `wb_valid`.
- `mem_req`, `mem_we`, `mem_addr`, `mem_be`, `mem_wdata` are registered and stable for the whole of ACCESS.
- `mem_ack` is ignored while `mem_req=0`, including a late ack after a timeout or reset.
- Timeout counter:
  - 16-bit, cleared on entry to ACCESS, increments each ACCESS cycle without ack.
  - At `TIMEOUT_CYCLES`: `mem_req` drops, `bus_err` pulses in the next cycle, no writeback.
- Ack in the same cycle the count reaches the limit: the ack wins; no `bus_err`.
- Reset values: `state=IDLE`, counter 0. `mem_req`, `mem_we`, `mem_be`, `wb_valid`, `bus_err`, `misaligned` are 0. `mem_addr`, `mem_wdata`, `wb_data`, `wb_rd` are 0.
- Reset during ACCESS: transaction discarded, `mem_req` low from the next cycle, no `wb_valid` or `bus_err`.

## Timing
- Pass-through: accept at edge N → `wb_valid` high in cycle N+1. Back-to-back accepts, one per cycle.
- Memory op accepted at edge N → `mem_req` high in cycle N+1.
- Ack in cycle N+k (k≥1) → `ex_ready` high and load `wb_valid` high in cycle N+k+1.
- Minimum load-to-writeback latency: 2 cycles.
- Timeout: `mem_req` high for `TIMEOUT_CYCLES` cycles; `bus_err` pulses the following cycle.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - Half access with `a[0]=1`, or word access with `a!=0`, issues no request.
  - `misaligned` pulses in cycle N+1, no writeback, state stays IDLE.
- Undefined:
  - Misalignment is not checked. The low address bits are ignored per size: half uses `a[1]`, word uses lane 0.
  - `misaligned` is constant 0.

## Structure
- Package `lsu_pkg`: `funct3` size constants, `lsu_state_t` enum {IDLE, ACCESS}, default `TIMEOUT_CYCLES`.
- Sub-module `lsu_align` (combinational): byte-enable generation, store lane replication, load extract/extend, misalignment detect.
- FSM, counter and registers live in `load_store_unit`.

## Test plan
- Pass-through: `ALUResult=0x0000_0011`, `RegWrite=1`, `RdIn=5` → next cycle `wb_valid=1`, `wb_data=0x11`, `wb_rd=5`, no `mem_req`.
- LB: addr `0x103`, `mem_rdata=0x80FF_FF00`, ack after 3 cycles → `mem_addr=0x100`, `mem_be=1000`, `wb_data=0xFFFF_FF80`. LBU of the same → `0x0000_0080`.
- SH: addr `0x22`, `WriteData=0x1234_ABCD` → `mem_be=1100`, `mem_wdata=0xABCD_ABCD`, `mem_we=1`, no `wb_valid`.
- Timeout with `TIMEOUT_CYCLES=4`, never ack → `mem_req` high 4 cycles, `bus_err` pulse, `ex_ready` returns. A late ack is ignored.
- LW at `0x6` → with `LSU_MISALIGN_TRAP_EN`: `misaligned` pulse, no `mem_req`. Without it: `mem_addr=0x4`, `be=1111`.
- `rst` asserted in the 2nd ACCESS cycle → `mem_req=0` next cycle, all outputs 0, a subsequent ack is ignored.
